mod_unit: RTL and testbench

Parametrised sequential integer divider/modulo unit with a start/done handshake, producing quotient and remainder of `a / b` in unsigned or signed (truncating) mode. Replaces the fixed 32-bit self-starting modulo wrapper: start is now driven by the requester, not free-running. Uses a radix-2 restoring shift-subtract datapath, one quotient bit per cycle, with divide-by-zero detection. Sits beside the ALU as a multi-cycle functional unit.

---
 rtl/mod_unit_if.sv | 25 ++
 rtl/mod_unit.sv | 95 +++++++++
 tb/tb_mod_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mod_unit_if.sv
// Requester-facing bundle of the divider: start/operands in, ready/done/results out.
// The master modport is the requester side; the slave modport is the divider.
interface mod_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_mode, a, b,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_mode, a, b,
    output ready, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/mod_unit.sv
// Restoring radix-2 divider/modulo, signed or unsigned; latency WIDTH+1 (1 on divide-by-zero).
// Backpressure: start is taken only while ready=1; requests while busy are dropped, not queued.
module mod_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mod_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, dvd, dvs;
  logic             q_neg, r_neg, dbz;
  logic             ready_c, accept, fix_c;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             done_q, dbz_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             b_zero;

  assign b_zero  = (bus.b == '0);
  assign a_mag   = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag   = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  // Quotient bits accumulate in dvd as the dividend bits shift out of its top.
  assign shifted = {rem, dvd[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = b_zero ? FIX : RUN;
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_c = (state == IDLE);
    accept  = ready_c && bus.start;
    fix_c   = (state == FIX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      rem    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dbz    <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      done_q <= fix_c;
      if (accept) begin
        dbz   <= b_zero;
        q_neg <= bus.signed_mode && !b_zero && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        r_neg <= bus.signed_mode && !b_zero && bus.a[WIDTH-1];
        // On divide-by-zero the raw dividend is parked here and returned untouched.
        dvd   <= b_zero ? bus.a : a_mag;
        dvs   <= b_mag;
        rem   <= '0;
        cnt   <= CW'(WIDTH - 1);
      end else if (state == RUN) begin
        rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
        cnt <= cnt - 1'b1;
      end
      if (fix_c) begin
        dbz_q  <= dbz;
        quot_q <= dbz ? '1  : (q_neg ? -dvd : dvd);
        rem_q  <= dbz ? dvd : (r_neg ? -rem : rem);
      end
    end
  end

  assign bus.ready       = ready_c;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mod_unit.sv
// Directed checks of mod_unit at WIDTH=8 and WIDTH=32, plus a reference-model sweep.
module tb_mod_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mod_unit_if #(.WIDTH(8))  if8 ();
  mod_unit_if #(.WIDTH(32)) if32 ();

  mod_unit #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(if8));
  mod_unit #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(if32));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge with the unit idle; returns at #1 after the done edge.
  task automatic op8(input logic sm, input logic [7:0] av, input logic [7:0] bv,
                     output logic [7:0] q, output logic [7:0] r, output logic z, output int lat);
    if8.start = 1'b1; if8.signed_mode = sm; if8.a = av; if8.b = bv;
    @(posedge clk); #1;
    if8.start = 1'b0;
    lat = 0;
    while (!if8.done && lat < 200) begin @(posedge clk); #1; lat++; end
    q = if8.quotient; r = if8.remainder; z = if8.div_by_zero;
  endtask

  task automatic op32(input logic sm, input logic [31:0] av, input logic [31:0] bv,
                      output logic [31:0] q, output logic [31:0] r, output logic z, output int lat);
    if32.start = 1'b1; if32.signed_mode = sm; if32.a = av; if32.b = bv;
    @(posedge clk); #1;
    if32.start = 1'b0;
    lat = 0;
    while (!if32.done && lat < 200) begin @(posedge clk); #1; lat++; end
    q = if32.quotient; r = if32.remainder; z = if32.div_by_zero;
  endtask

  logic [7:0]  q8, r8, ea8, eb8, eq8, er8;
  logic [31:0] q32, r32, ea32, eb32, eq32, er32;
  logic        z;
  int          lat;
  longint      sa, sb;
  int          acc [3];
  int          nacc;
  int          ndone;

  initial begin
    if8.start = 1'b0;  if8.signed_mode = 1'b0;  if8.a = '0;  if8.b = '0;
    if32.start = 1'b0; if32.signed_mode = 1'b0; if32.a = '0; if32.b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_ready", {63'd0, if8.ready}, 64'd1);
    chk("rst_done", {63'd0, if8.done}, 64'd0);
    chk("rst_q", {56'd0, if8.quotient}, 64'd0);
    chk("rst_r", {56'd0, if8.remainder}, 64'd0);
    chk("rst_dbz", {63'd0, if32.div_by_zero}, 64'd0);

    // 32-bit unsigned and divide-by-zero latency
    op32(1'b0, 32'd100, 32'd7, q32, r32, z, lat);
    chk("u32_lat", 64'(lat), 64'd33);
    chk("u32_q", {32'd0, q32}, 64'd14);
    chk("u32_r", {32'd0, r32}, 64'd2);
    chk("u32_z", {63'd0, z}, 64'd0);
    op32(1'b0, 32'h1234, 32'd0, q32, r32, z, lat);
    chk("dbz32_lat", 64'(lat), 64'd1);
    chk("dbz32_q", {32'd0, q32}, 64'hFFFF_FFFF);
    chk("dbz32_r", {32'd0, r32}, 64'h1234);
    chk("dbz32_z", {63'd0, z}, 64'd1);
    @(posedge clk); #1;
    chk("done_pulse", {63'd0, if32.done}, 64'd0);

    // 8-bit signed corners
    op8(1'b1, 8'hF9, 8'h02, q8, r8, z, lat);
    chk("s8_lat", 64'(lat), 64'd9);
    chk("s8a_q", {56'd0, q8}, 64'hFD);
    chk("s8a_r", {56'd0, r8}, 64'hFF);
    op8(1'b1, 8'h07, 8'hFE, q8, r8, z, lat);
    chk("s8b_q", {56'd0, q8}, 64'hFD);
    chk("s8b_r", {56'd0, r8}, 64'h01);
    op8(1'b1, 8'h80, 8'hFF, q8, r8, z, lat);
    chk("ovf_q", {56'd0, q8}, 64'h80);
    chk("ovf_r", {56'd0, r8}, 64'h00);
    chk("ovf_z", {63'd0, z}, 64'd0);
    op8(1'b1, 8'h85, 8'h00, q8, r8, z, lat);
    chk("dbz8_q", {56'd0, q8}, 64'hFF);
    chk("dbz8_r", {56'd0, r8}, 64'h85);
    chk("dbz8_z", {63'd0, z}, 64'd1);
    op8(1'b0, 8'hF9, 8'h02, q8, r8, z, lat);
    chk("u8_q", {56'd0, q8}, 64'h7C);
    chk("u8_r", {56'd0, r8}, 64'h01);

    // start pulsed mid-RUN is dropped; operand changes after accept have no effect
    if8.start = 1'b1; if8.signed_mode = 1'b0; if8.a = 8'd100; if8.b = 8'd7;
    @(posedge clk); #1;
    if8.start = 1'b0;
    chk("busy_ready", {63'd0, if8.ready}, 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    if8.start = 1'b1; if8.a = 8'd50; if8.b = 8'd5;
    @(posedge clk); #1;
    if8.start = 1'b0; if8.a = 8'd0; if8.b = 8'd0;
    lat = 4;
    while (!if8.done && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("busy_lat", 64'(lat), 64'd9);
    chk("busy_q", {56'd0, if8.quotient}, 64'd14);
    chk("busy_r", {56'd0, if8.remainder}, 64'd2);
    @(posedge clk); #1;
    chk("busy_noreq", {63'd0, if8.ready}, 64'd1);

    // start held high: accepts every WIDTH+2 cycles
    if8.start = 1'b1; if8.a = 8'd200; if8.b = 8'd9;
    nacc = 0;
    for (int i = 0; i < 60 && nacc < 3; i++) begin
      if (if8.ready) begin acc[nacc] = i; nacc++; end
      @(posedge clk); #1;
    end
    if8.start = 1'b0;
    chk("hold_n", 64'(nacc), 64'd3);
    if (nacc == 3) begin
      chk("hold_gap1", 64'(acc[1] - acc[0]), 64'd10);
      chk("hold_gap2", 64'(acc[2] - acc[1]), 64'd10);
    end
    lat = 0;
    while (!if8.done && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("hold_q", {56'd0, if8.quotient}, 64'd22);

    // reset during RUN aborts without a done
    if8.start = 1'b1; if8.a = 8'd100; if8.b = 8'd7;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("abort_ready", {63'd0, if8.ready}, 64'd1);
    chk("abort_q", {56'd0, if8.quotient}, 64'd0);
    chk("abort_r", {56'd0, if8.remainder}, 64'd0);
    chk("abort_done", {63'd0, if8.done}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    ndone = 0;
    repeat (12) begin @(posedge clk); #1; if (if8.done) ndone++; end
    chk("abort_nodone", 64'(ndone), 64'd0);
    op8(1'b0, 8'd200, 8'd9, q8, r8, z, lat);
    chk("post_q", {56'd0, q8}, 64'd22);
    chk("post_r", {56'd0, r8}, 64'd2);

    // reference sweep against the language's truncating / and %
    for (int i = 0; i < 150; i++) begin
      ea8 = 8'($urandom); eb8 = 8'($urandom);
      if (eb8 == 8'd0) eb8 = 8'd1;
      z = 1'($urandom_range(0, 1));
      if (z) begin
        sa = longint'($signed(ea8)); sb = longint'($signed(eb8));
        eq8 = 8'(sa / sb); er8 = 8'(sa % sb);
      end else begin
        eq8 = ea8 / eb8; er8 = ea8 % eb8;
      end
      op8(z, ea8, eb8, q8, r8, z, lat);
      chk("sw8_q", {56'd0, q8}, {56'd0, eq8});
      chk("sw8_r", {56'd0, r8}, {56'd0, er8});
    end
    for (int i = 0; i < 150; i++) begin
      ea32 = $urandom; eb32 = $urandom;
      if (i % 3 == 0) eb32 = eb32 >> $urandom_range(4, 28);
      if (eb32 == 32'd0) eb32 = 32'd3;
      z = 1'($urandom_range(0, 1));
      if (z) begin
        sa = longint'($signed(ea32)); sb = longint'($signed(eb32));
        eq32 = 32'(sa / sb); er32 = 32'(sa % sb);
      end else begin
        eq32 = ea32 / eb32; er32 = ea32 % eb32;
      end
      op32(z, ea32, eb32, q32, r32, z, lat);
      chk("sw32_q", {32'd0, q32}, {32'd0, eq32});
      chk("sw32_r", {32'd0, r32}, {32'd0, er32});
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
